// File: rtl/qubit_measure_sampler.sv
// qubit_measure_sampler
//   Converts a single-qubit outcome-0 probability into a burst of simulated
//   measurement shots. Each shot consumes one 32-bit word from the PRNG
//   (xorshift32) through a valid/ack handshake. The top PROB_W bits of that
//   word are compared against prob0 to produce one outcome bit. The block
//   also keeps a running count of 1-outcomes.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle burst request, accepted only when idle
//   prob0          outcome-0 probability, p0 = prob0 / 2^PROB_W
//   num_shots      shots in the burst (0 is legal)
//   rand_in        random word from the PRNG
//   rand_valid     rand_in holds a fresh word
//   rand_ack       word consumed this cycle (combinational)
//   outcome        measured bit of the most recent shot
//   outcome_valid  one-cycle pulse, outcome is valid
//   ones_count     1-outcomes since the last accepted start
//   busy           burst in progress, up to and including the done cycle
//   done           one-cycle pulse at the end of the burst
//   stall_count    DRAW cycles without rand_valid, saturating
//                  (present only when MEAS_STALL_CNT_EN is defined)
//
// Optional feature macro: MEAS_STALL_CNT_EN

module qubit_measure_sampler #(
    parameter int unsigned PROB_W  = 16,
    parameter int unsigned SHOTS_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PROB_W-1:0]  prob0,
    input  logic [SHOTS_W-1:0] num_shots,
    input  logic [31:0]        rand_in,
    input  logic               rand_valid,
    output logic               rand_ack,
    output logic               outcome,
    output logic               outcome_valid,
    output logic [SHOTS_W-1:0] ones_count,
    output logic               busy,
    output logic               done
`ifdef MEAS_STALL_CNT_EN
    ,
    output logic [SHOTS_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [PROB_W-1:0]  prob_q, prob_d;
    logic [SHOTS_W-1:0] shots_q, shots_d;
    logic [SHOTS_W-1:0] shot_cnt_q, shot_cnt_d;
    logic               outcome_q, outcome_d;
    logic               outcome_valid_q, outcome_valid_d;
    logic [SHOTS_W-1:0] ones_q, ones_d;
`ifdef MEAS_STALL_CNT_EN
    logic [SHOTS_W-1:0] stall_q, stall_d;
`endif

    logic [PROB_W-1:0]  sample;
    logic               draw_one;
    logic [SHOTS_W-1:0] shot_cnt_inc;
    logic               unused_rand_bits;

    // Only the top PROB_W bits of the word are used as the sample.
    assign sample           = rand_in[31 -: PROB_W];
    assign unused_rand_bits = ^rand_in;
    assign draw_one         = (sample >= prob_q);
    assign shot_cnt_inc     = shot_cnt_q + SHOTS_W'(1);

    always_comb begin
        state_d         = state_q;
        prob_d          = prob_q;
        shots_d         = shots_q;
        shot_cnt_d      = shot_cnt_q;
        outcome_d       = outcome_q;
        outcome_valid_d = 1'b0;
        ones_d          = ones_q;
`ifdef MEAS_STALL_CNT_EN
        stall_d         = stall_q;
`endif
        rand_ack        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    prob_d     = prob0;
                    shots_d    = num_shots;
                    shot_cnt_d = '0;
                    ones_d     = '0;
`ifdef MEAS_STALL_CNT_EN
                    stall_d    = '0;
`endif
                    state_d    = (num_shots == '0) ? StFinish : StDraw;
                end
            end
            StDraw: begin
                if (rand_valid) begin
                    rand_ack        = 1'b1;
                    shot_cnt_d      = shot_cnt_inc;
                    outcome_d       = draw_one;
                    outcome_valid_d = 1'b1;
                    ones_d          = ones_q + SHOTS_W'(draw_one);
                    // Equality compare: num_shots = all-ones is reached without wrap.
                    if (shot_cnt_inc == shots_q) begin
                        state_d = StFinish;
                    end
                end else begin
`ifdef MEAS_STALL_CNT_EN
                    if (stall_q != '1) begin
                        stall_d = stall_q + SHOTS_W'(1);
                    end
`endif
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            prob_q          <= '0;
            shots_q         <= '0;
            shot_cnt_q      <= '0;
            outcome_q       <= 1'b0;
            outcome_valid_q <= 1'b0;
            ones_q          <= '0;
`ifdef MEAS_STALL_CNT_EN
            stall_q         <= '0;
`endif
        end else begin
            state_q         <= state_d;
            prob_q          <= prob_d;
            shots_q         <= shots_d;
            shot_cnt_q      <= shot_cnt_d;
            outcome_q       <= outcome_d;
            outcome_valid_q <= outcome_valid_d;
            ones_q          <= ones_d;
`ifdef MEAS_STALL_CNT_EN
            stall_q         <= stall_d;
`endif
        end
    end

    assign outcome       = outcome_q;
    assign outcome_valid = outcome_valid_q;
    assign ones_count    = ones_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StFinish);
`ifdef MEAS_STALL_CNT_EN
    assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_qubit_measure_sampler.sv
// tb_qubit_measure_sampler
//   Directed bench for qubit_measure_sampler: table of single-shot vectors
//   plus hand-written burst sequences (reset, latency, zero shots, stalls,
//   ignored start, abort, xorshift32 statistics).

module tb_qubit_measure_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] prob0;
    logic [15:0] num_shots;
    logic [31:0] rand_in;
    logic        rand_valid;
    logic        rand_ack;
    logic        outcome;
    logic        outcome_valid;
    logic [15:0] ones_count;
    logic        busy;
    logic        done;
`ifdef MEAS_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    qubit_measure_sampler #(
        .PROB_W (16),
        .SHOTS_W(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prob0        (prob0),
        .num_shots    (num_shots),
        .rand_in      (rand_in),
        .rand_valid   (rand_valid),
        .rand_ack     (rand_ack),
        .outcome      (outcome),
        .outcome_valid(outcome_valid),
        .ones_count   (ones_count),
        .busy         (busy),
        .done         (done)
`ifdef MEAS_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    typedef struct {
        logic [15:0] prob;
        logic [31:0] rnd;
        logic        exp_out;
    } vec_t;

    vec_t vecs[11];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] words[$];
    bit          valid_pat[$];
    bit          outs[$];
    int          wp, vi, cyc, ack_cnt, done_cnt, start_cyc, done_cyc, model_ones;
    logic [15:0] ones_at_done;
    logic        busy_at_done;
    logic [15:0] cur_prob;
    bit          use_xs;
    logic [31:0] xs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xorshift(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [31:0] cur_word();
        if (use_xs) return xs;
        if (wp < words.size()) return words[wp];
        return 32'h0;
    endfunction

    function automatic logic next_valid();
        logic v;
        v = 1'b1;
        if (vi < valid_pat.size()) v = valid_pat[vi];
        vi++;
        return v;
    endfunction

    // One clock: sample at negedge, drive new inputs 1 time unit after posedge.
    task automatic cycle();
        @(negedge clk);
        if (rand_ack) begin
            ack_cnt++;
            if (rand_in[31:16] >= cur_prob) model_ones++;
            if (use_xs) xs = xorshift(xs);
            else wp++;
        end
        if (outcome_valid) outs.push_back(outcome);
        if (done) begin
            if (done_cnt == 0) begin
                done_cyc     = cyc;
                ones_at_done = ones_count;
                busy_at_done = busy;
            end
            done_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        rand_in    = cur_word();
        rand_valid = next_valid();
    endtask

    task automatic begin_burst(input logic [15:0] p, input logic [15:0] n);
        wp         = 0;
        vi         = 0;
        ack_cnt    = 0;
        done_cnt   = 0;
        model_ones = 0;
        outs.delete();
        cur_prob   = p;
        start      = 1'b1;
        prob0      = p;
        num_shots  = n;
        rand_in    = cur_word();
        rand_valid = 1'b0;
        start_cyc  = cyc;
        cycle();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            cycle();
            k++;
        end
        chk("done_seen", done_cnt, 1);
    endtask

    initial begin
        logic [3:0] ov;

        vecs[0]  = '{16'h8000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{16'h8000, 32'hFFFF_FFFF, 1'b1};
        vecs[2]  = '{16'h8000, 32'h7FFF_FFFF, 1'b0};
        vecs[3]  = '{16'h8000, 32'h8000_0000, 1'b1};
        vecs[4]  = '{16'h0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{16'hFFFF, 32'hFFFF_0000, 1'b1};
        vecs[6]  = '{16'hFFFF, 32'hFFFE_FFFF, 1'b0};
        vecs[7]  = '{16'h4000, 32'h3FFF_1234, 1'b0};
        vecs[8]  = '{16'h4000, 32'h4000_0000, 1'b1};
        vecs[9]  = '{16'h0001, 32'h0000_FFFF, 1'b0};
        vecs[10] = '{16'h0001, 32'h0001_0000, 1'b1};

        use_xs     = 1'b0;
        xs         = 32'h1234_5678;
        cyc        = 0;
        cur_prob   = 16'h0;
        reset      = 1'b0;
        start      = 1'b1;
        prob0      = 16'h8000;
        num_shots  = 16'd4;
        rand_in    = 32'hFFFF_FFFF;
        rand_valid = 1'b1;

        // Reset held with start high: everything quiet.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", {outcome, outcome_valid, ones_count, busy, done, rand_ack}, 0);
`ifdef MEAS_STALL_CNT_EN
            chk("reset_stall", stall_count, 0);
`endif
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        rand_valid = 1'b0;
        reset      = 1'b1;
        cycle();

        // Alternating words, p0 = 0.5.
        words = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        begin_burst(16'h8000, 16'd4);
        wait_done(20);
        ov = 4'hx;
        if (outs.size() == 4) ov = {outs[0], outs[1], outs[2], outs[3]};
        chk("alt_outcomes", ov, 4'b0101);
        chk("alt_ones", ones_at_done, 2);
        chk("alt_latency", done_cyc - start_cyc, 5);
        chk("alt_busy_done", busy_at_done, 1);
        cycle();
        cycle();
        chk("alt_ones_hold", ones_count, 2);
        chk("alt_idle_busy", busy, 0);

        // prob0 = 0: all ones.
        words = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        begin_burst(16'h0000, 16'd8);
        wait_done(20);
        chk("p0zero_ones", ones_at_done, 8);
        chk("p0zero_nout", outs.size(), 8);

        // Zero shots.
        begin_burst(16'h8000, 16'd0);
        wait_done(5);
        chk("zero_latency", done_cyc - start_cyc, 1);
        chk("zero_acks", ack_cnt, 0);
        chk("zero_nout", outs.size(), 0);
        chk("zero_ones", ones_at_done, 0);

        // Single-shot vector table.
        for (int i = 0; i < 11; i++) begin
            words.delete();
            words.push_back(vecs[i].rnd);
            begin_burst(vecs[i].prob, 16'd1);
            wait_done(10);
            chk($sformatf("vec%0d_out", i), (outs.size() > 0) ? outs[0] : 1'bx, vecs[i].exp_out);
            chk($sformatf("vec%0d_ones", i), ones_at_done, vecs[i].exp_out);
            chk($sformatf("vec%0d_lat", i), done_cyc - start_cyc, 2);
        end

        // Stalls: valid 1,0,0,1,0,1 over the DRAW cycles.
        words     = '{32'h0, 32'h0, 32'h0};
        valid_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        begin_burst(16'h8000, 16'd3);
        wait_done(20);
        valid_pat.delete();
        chk("stall_acks", ack_cnt, 3);
        chk("stall_latency", done_cyc - start_cyc, 7);
`ifdef MEAS_STALL_CNT_EN
        chk("stall_count", stall_count, 3);
`endif

        // Second start mid-burst is ignored.
        words = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        begin_burst(16'h8000, 16'd5);
        cycle();
        start     = 1'b1;
        num_shots = 16'd1;
        prob0     = 16'h0000;
        cycle();
        start     = 1'b0;
        wait_done(20);
        chk("ign_acks", ack_cnt, 5);
        chk("ign_latency", done_cyc - start_cyc, 6);
        chk("ign_ones", ones_at_done, 3);

        // Abort by reset after shot 2.
        words = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        begin_burst(16'h8000, 16'd5);
        cycle();
        cycle();
        chk("abort_acks", ack_cnt, 2);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_flags", {done, rand_ack, outcome_valid}, 0);
        cycle();
        cycle();
        reset    = 1'b1;
        done_cnt = 0;
        repeat (8) cycle();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_ones", ones_count, 0);

        // Statistics from a live xorshift32 stream, p0 = 0.25.
        use_xs = 1'b1;
        begin_burst(16'h4000, 16'd4096);
        wait_done(5000);
        use_xs = 1'b0;
        chk("stat_acks", ack_cnt, 4096);
        chk("stat_model", ones_at_done, model_ones);
        chk("stat_range", (ones_at_done >= 16'd2944 && ones_at_done <= 16'd3200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
